dsp32_instr_fetch: RTL and testbench

- Instruction fetch/prefetch unit for the DSP32 core; the read side of the 2K x 16 dual-port instruction memory.
- The host writes the memory through port A. This block owns port B and drives address, clock-enable and output-enable.
- It captures read data (bypass read mode, 1-cycle latency) into a small prefetch FIFO and presents instructions to the decoder over a valid/ready handshake.
- Supports start/stop and branch redirect with squash of in-flight reads.

---
 rtl/dsp32_instr_fetch.sv | 121 ++++++++++++
 tb/tb_dsp32_instr_fetch.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp32_instr_fetch.sv
// rtl/dsp32_instr_fetch.sv - DSP32 instruction fetch: port B reader, prefetch FIFO, redirect squash
module dsp32_instr_fetch #(
   parameter int                ADDR_W     = 11,
   parameter int                DATA_W     = 16,
   parameter int                FIFO_DEPTH = 4,
   parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              run,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic [ADDR_W-1:0] mem_adb,
   output logic              mem_ceb,
   output logic              mem_oceb,
   output logic              mem_wreb,
   output logic              mem_resetb,
   input  logic [DATA_W-1:0] mem_doutb,
   output logic              instr_valid,
   output logic [DATA_W-1:0] instr_data,
   output logic [ADDR_W-1:0] instr_pc,
   input  logic              instr_ready,
   output logic [ADDR_W-1:0] fetch_pc,
   output logic              idle
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_DRAIN} state_t;

   state_t            state_q;
   logic [ADDR_W-1:0] fetch_pc_q;
   logic [ADDR_W-1:0] infl_pc_q;
   logic              inflight_q;
   logic              infl_epoch_q;
   logic              epoch_q;
   logic [DATA_W-1:0] data_q [FIFO_DEPTH];
   logic [ADDR_W-1:0] pc_q   [FIFO_DEPTH];
   logic [PW-1:0]     rd_ptr_q;
   logic [PW-1:0]     wr_ptr_q;
   logic [CW-1:0]     count_q;

   logic              issue;
   logic              push;
   logic              pop;
   logic              empty;
   logic [CW:0]       occupancy;

   // Reserve a FIFO slot for the in-flight read so its data always has room.
   assign empty     = (count_q == '0);
   assign occupancy = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
   assign issue     = reset_n && run && !redirect_valid && (occupancy < (CW+1)'(FIFO_DEPTH));
   assign push      = inflight_q && (infl_epoch_q == epoch_q);
   assign pop       = !empty && instr_ready;

   assign mem_adb     = fetch_pc_q;
   assign mem_ceb     = issue;
   assign mem_oceb    = 1'b1;
   assign mem_wreb    = 1'b0;
   assign mem_resetb  = 1'b0;
   assign fetch_pc    = fetch_pc_q;
   assign instr_valid = !empty;
   assign instr_data  = empty ? '0 : data_q[rd_ptr_q];
   assign instr_pc    = empty ? '0 : pc_q[rd_ptr_q];
   assign idle        = !reset_n || (!run && !inflight_q && empty && (state_q != ST_DRAIN));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         fetch_pc_q   <= RESET_PC;
         infl_pc_q    <= '0;
         inflight_q   <= 1'b0;
         infl_epoch_q <= 1'b0;
         epoch_q      <= 1'b0;
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         count_q      <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            data_q[i] <= '0;
            pc_q[i]   <= '0;
         end
      end else begin
         inflight_q <= issue;
         if (issue) begin
            fetch_pc_q   <= fetch_pc_q + ADDR_W'(1);
            infl_pc_q    <= fetch_pc_q;
            infl_epoch_q <= epoch_q;
         end

         // Flush beats any same-cycle push or pop.
         if (redirect_valid) begin
            fetch_pc_q <= redirect_pc;
            epoch_q    <= ~epoch_q;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
         end else begin
            if (push) begin
               data_q[wr_ptr_q] <= mem_doutb;
               pc_q[wr_ptr_q]   <= infl_pc_q;
               wr_ptr_q         <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
               rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push, pop})
               2'b10:   count_q <= count_q + CW'(1);
               2'b01:   count_q <= count_q - CW'(1);
               default: count_q <= count_q;
            endcase
         end

         case (state_q)
            ST_IDLE:  if (run) state_q <= ST_FETCH;
            ST_FETCH: if (!run) state_q <= inflight_q ? ST_DRAIN : ST_IDLE;
            ST_DRAIN: state_q <= run ? ST_FETCH : ST_IDLE;
            default:  state_q <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_dsp32_instr_fetch.sv
// tb/tb_dsp32_instr_fetch.sv - directed scoreboard bench for dsp32_instr_fetch
module tb_dsp32_instr_fetch;
   localparam int ADDR_W     = 11;
   localparam int DATA_W     = 16;
   localparam int FIFO_DEPTH = 4;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              run = 1'b0;
   logic              redirect_valid = 1'b0;
   logic [ADDR_W-1:0] redirect_pc = '0;
   logic              instr_ready = 1'b0;
   logic [ADDR_W-1:0] mem_adb, instr_pc, fetch_pc;
   logic              mem_ceb, mem_oceb, mem_wreb, mem_resetb, instr_valid, idle;
   logic [DATA_W-1:0] mem_doutb = '0;
   logic [DATA_W-1:0] instr_data;
   logic [DATA_W-1:0] mem [2**ADDR_W];

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [DATA_W-1:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   dsp32_instr_fetch #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .RESET_PC(11'h000)
   ) dut (
      .clk(clk), .reset_n(reset_n), .run(run),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .mem_adb(mem_adb), .mem_ceb(mem_ceb), .mem_oceb(mem_oceb),
      .mem_wreb(mem_wreb), .mem_resetb(mem_resetb), .mem_doutb(mem_doutb),
      .instr_valid(instr_valid), .instr_data(instr_data), .instr_pc(instr_pc),
      .instr_ready(instr_ready), .fetch_pc(fetch_pc), .idle(idle)
   );

   always #5 clk = ~clk;

   // Port B in bypass read mode: address sampled at the edge, data visible the next cycle.
   always @(posedge clk) if (mem_ceb) mem_doutb <= mem[mem_adb];

   function automatic exp_t mk(input int pc);
      exp_t e;
      e.pc   = ADDR_W'(pc);
      e.data = {5'b0, ADDR_W'(pc)} ^ 16'hA500;
      return e;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (reset_n && instr_valid === 1'b1 && instr_ready) begin
         check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("sb_pc", 32'(instr_pc), 32'(e.pc));
            check("sb_data", 32'(instr_data), 32'(e.data));
         end
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic r, input logic rdy);
      reset_n        = 1'b0;
      run            = r;
      instr_ready    = rdy;
      redirect_valid = 1'b0;
      #1;
      check("leftover_exp", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      check("rst_ceb", 32'(mem_ceb), 32'd0);
      check("rst_adb", 32'(mem_adb), 32'd0);
      check("rst_valid", 32'(instr_valid), 32'd0);
      check("rst_data", 32'(instr_data), 32'd0);
      check("rst_pc", 32'(instr_pc), 32'd0);
      check("rst_idle", 32'(idle), 32'd1);
      check("rst_fetch_pc", 32'(fetch_pc), 32'd0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 2**ADDR_W; i++) mem[i] = 16'(i) ^ 16'hA500;

      // Reset, constant port B controls, then free-running stream.
      do_reset(1'b1, 1'b1);
      check("const_oceb", 32'(mem_oceb), 32'd1);
      check("const_wreb", 32'(mem_wreb), 32'd0);
      check("const_resetb", 32'(mem_resetb), 32'd0);
      for (int i = 0; i < 10; i++) exp_q.push_back(mk(i));
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (c == 0) begin
            check("t1_ceb0", 32'(mem_ceb), 32'd1);
            check("t1_adb0", 32'(mem_adb), 32'd0);
         end
         check("t1_valid", 32'(instr_valid), 32'(c >= 2));
         next_cycle();
      end

      // Decoder stalled: FIFO fills with exactly four reads.
      do_reset(1'b1, 1'b0);
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         check("t2_ceb", 32'(mem_ceb), 32'(c < 4));
         if (c == 7) begin
            check("t2_fetch_pc", 32'(fetch_pc), 32'd4);
            check("t2_valid", 32'(instr_valid), 32'd1);
            check("t2_head_pc", 32'(instr_pc), 32'd0);
            check("t2_head_data", 32'(instr_data), 32'hA500);
         end
         next_cycle();
      end
      exp_q.push_back(mk(0));
      instr_ready = 1'b1;
      @(negedge clk);
      check("t2_full_ceb", 32'(mem_ceb), 32'd0);
      next_cycle();
      instr_ready = 1'b0;
      @(negedge clk);
      check("t2_refill_ceb", 32'(mem_ceb), 32'd1);
      check("t2_refill_adb", 32'(mem_adb), 32'd4);
      next_cycle();
      @(negedge clk);
      check("t2_after_ceb", 32'(mem_ceb), 32'd0);
      check("t2_next_pc", 32'(instr_pc), 32'd1);
      check("t2_next_data", 32'(instr_data), 32'hA501);
      next_cycle();

      // Redirect to 0x123 right after the pc 7 issue.
      do_reset(1'b1, 1'b1);
      for (int i = 0; i < 6; i++) exp_q.push_back(mk(i));
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (c == 7) check("t3_issue7", 32'(mem_adb), 32'd7);
         next_cycle();
      end
      redirect_valid = 1'b1;
      redirect_pc    = 11'h123;
      instr_ready    = 1'b0;
      @(negedge clk);
      check("t3_redir_ceb", 32'(mem_ceb), 32'd0);
      next_cycle();
      redirect_valid = 1'b0;
      instr_ready    = 1'b1;
      @(negedge clk);
      check("t3_flushed", 32'(instr_valid), 32'd0);
      check("t3_ceb", 32'(mem_ceb), 32'd1);
      check("t3_adb", 32'(mem_adb), 32'h123);
      next_cycle();
      @(negedge clk);
      check("t3_gap", 32'(instr_valid), 32'd0);
      for (int i = 0; i < 3; i++) exp_q.push_back(mk(32'h123 + i));
      next_cycle();
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("t3_valid", 32'(instr_valid), 32'd1);
         next_cycle();
      end

      // Address wrap at the top of memory.
      do_reset(1'b1, 1'b1);
      redirect_valid = 1'b1;
      redirect_pc    = 11'h7FE;
      exp_q.push_back(mk(32'h7FE));
      exp_q.push_back(mk(32'h7FF));
      exp_q.push_back(mk(32'h000));
      exp_q.push_back(mk(32'h001));
      @(negedge clk);
      check("t4_redir_ceb", 32'(mem_ceb), 32'd0);
      next_cycle();
      redirect_valid = 1'b0;
      for (int c = 1; c < 7; c++) begin
         @(negedge clk);
         check("t4_valid", 32'(instr_valid), 32'(c >= 3));
         next_cycle();
      end

      // run drops with two entries buffered and one read in flight.
      do_reset(1'b1, 1'b0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         next_cycle();
      end
      run = 1'b0;
      @(negedge clk);
      check("t5_stop_ceb", 32'(mem_ceb), 32'd0);
      check("t5_busy", 32'(idle), 32'd0);
      next_cycle();
      @(negedge clk);
      check("t5_hold_ceb", 32'(mem_ceb), 32'd0);
      check("t5_valid", 32'(instr_valid), 32'd1);
      next_cycle();
      for (int i = 0; i < 3; i++) exp_q.push_back(mk(i));
      instr_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("t5_drain_ceb", 32'(mem_ceb), 32'd0);
         next_cycle();
      end
      @(negedge clk);
      check("t5_empty", 32'(instr_valid), 32'd0);
      check("t5_idle", 32'(idle), 32'd1);
      next_cycle();

      // Reset lands while a read is in flight.
      do_reset(1'b1, 1'b1);
      for (int i = 0; i < 3; i++) exp_q.push_back(mk(i));
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (c == 4) check("t6_inflight_issue", 32'(mem_ceb), 32'd1);
         next_cycle();
      end
      do_reset(1'b1, 1'b1);
      exp_q.push_back(mk(0));
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("t6_valid", 32'(instr_valid), 32'(c >= 2));
         next_cycle();
      end
      check("final_leftover", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
